apb_fifo_writer: RTL and testbench

APB_FIFO_WRITER -- requirements
Module: apb_fifo_writer

---
 rtl/apb_fifo_writer.sv | 152 +++++++++++++++
 tb/tb_apb_fifo_writer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_fifo_writer.sv
// APB slave that pushes DATA writes into a FIFO, stalling on full
// with a bounded wait, plus STATUS/CTRL registers.
module apb_fifo_writer #(
  parameter int WAIT_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [3:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  input  logic        full,
  output logic        write,
  output logic [31:0] data_write
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FULL,
    PUSH,
    RESP
  } state_t;

  localparam logic [4:0] LAST = 5'(WAIT_MAX - 1);

  state_t      state;
  state_t      next;
  logic [4:0]  wait_cnt;
  logic [31:0] data_q;
  logic        enable;
  logic        ovf;
  logic [7:0]  push_count;

  logic        access;
  logic [1:0]  sel;
  logic        data_wr;
  logic        bad;
  logic        rd_ok;
  logic        ctrl_wr;
  logic        clear;
  logic        timeout;
  logic        err_next;
  logic [31:0] rd_val;
  logic [31:0] status_word;
  logic [31:0] push_data;
  logic        unused;

  assign unused = ^paddr[1:0];

  assign access  = (state == IDLE) && psel && penable;
  assign sel     = paddr[3:2];
  assign data_wr = access && (sel == 2'd0) && pwrite && enable;
  assign rd_ok   = access && !pwrite
                && ((sel == 2'd1) || (sel == 2'd2));
  assign ctrl_wr = access && pwrite && (sel == 2'd2);
  assign clear   = ctrl_wr && pwdata[1];
  assign timeout = (state == WAIT_FULL) && full
                && (wait_cnt == LAST);

  // Disabled DATA writes fall into the error bucket too.
  assign bad = access && (
                 ((sel == 2'd0) && !pwrite)
              || ((sel == 2'd0) && pwrite && !enable)
              || ((sel == 2'd1) && pwrite)
              ||  (sel == 2'd3));

  assign status_word = {16'd0, push_count, 6'd0, ovf, full};
  assign push_data   = (state == IDLE) ? pwdata : data_q;

  always_comb begin
    next     = state;
    err_next = 1'b0;
    rd_val   = '0;
    unique case (state)
      IDLE: begin
        if (data_wr) begin
          next = full ? WAIT_FULL : PUSH;
        end else if (access) begin
          next     = RESP;
          err_next = bad;
          if (rd_ok) begin
            rd_val = (sel == 2'd1) ? status_word
                                   : {31'd0, enable};
          end
        end
      end
      WAIT_FULL: begin
        if (!full) begin
          next = PUSH;
        end else if (wait_cnt == LAST) begin
          next     = RESP;
          err_next = 1'b1;
        end
      end
      PUSH: next = IDLE;
      RESP: next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      write      <= 1'b0;
      data_write <= '0;
      pready     <= 1'b0;
      pslverr    <= 1'b0;
      prdata     <= '0;
      enable     <= 1'b1;
      ovf        <= 1'b0;
      push_count <= '0;
      wait_cnt   <= '0;
      data_q     <= '0;
    end else begin
      state      <= next;
      write      <= (next == PUSH);
      data_write <= (next == PUSH) ? push_data : '0;
      pready     <= (next == PUSH) || (next == RESP);
      pslverr    <= err_next;
      prdata     <= rd_val;
      if (access) begin
        data_q <= pwdata;
      end
      // The decode cycle already saw full=1, so it counts as the first.
      if (state == IDLE && next == WAIT_FULL) begin
        wait_cnt <= 5'd1;
      end else if (state == WAIT_FULL && next == WAIT_FULL) begin
        wait_cnt <= wait_cnt + 5'd1;
      end else begin
        wait_cnt <= '0;
      end
      if (ctrl_wr) begin
        enable <= pwdata[0];
      end
      if (clear) begin
        ovf <= 1'b0;
      end else if (timeout) begin
        ovf <= 1'b1;
      end
      if (clear) begin
        push_count <= '0;
      end else if (write) begin
        push_count <= push_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_apb_fifo_writer.sv
// Directed bench for apb_fifo_writer: latency, stall, timeout,
// register access, counter wrap and reset abort.
module tb_apb_fifo_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        full;
  logic        write;
  logic [31:0] data_write;

  int          errors = 0;
  int          checks = 0;
  int          pushes = 0;
  int          bad_strobe = 0;
  logic [31:0] last_data = '0;

  logic [31:0] rd;
  logic        err;
  int          lat;
  int          p0;

  apb_fifo_writer #(.WAIT_MAX(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr),
    .full       (full),
    .write      (write),
    .data_write (data_write)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (write) begin
      pushes++;
      last_data = data_write;
      if (!pready || pslverr) bad_strobe++;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               tag, act, exp);
    end
  endtask

  task automatic apb(input logic wr, input logic [3:0] a,
                     input logic [31:0] d,
                     output logic [31:0] rdv,
                     output logic e, output int l);
    @(negedge clk);
    psel = 1'b1; pwrite = wr; paddr = a; pwdata = d;
    penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    l = 0;
    while (l < 100) begin
      @(posedge clk); #1;
      l++;
      if (pready) break;
    end
    rdv = prdata;
    e = pslverr;
    psel = 1'b0; penable = 1'b0;
    pwdata = 32'h5A5A_5A5A;
  endtask

  initial begin
    psel = 0; penable = 0; pwrite = 0; paddr = 0;
    pwdata = 0; full = 0; rst = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pready", {31'd0, pready}, 0);
    check("rst_write", {31'd0, write}, 0);
    check("rst_prdata", prdata, 0);
    check("rst_pslverr", {31'd0, pslverr}, 0);
    check("rst_dwrite", data_write, 0);
    rst = 0;

    apb(0, 4'h8, 0, rd, err, lat);
    check("ctrl_def", rd, 32'h1);
    check("ctrl_lat", lat, 1);

    p0 = pushes;
    apb(1, 4'h0, 32'hDEADBEEF, rd, err, lat);
    check("push_lat", lat, 1);
    check("push_err", {31'd0, err}, 0);
    check("push_prdata", rd, 0);
    #10;
    check("push_n", pushes - p0, 1);
    check("push_data", last_data, 32'hDEADBEEF);
    apb(0, 4'h4, 0, rd, err, lat);
    check("stat_cnt1", rd, 32'h0000_0100);

    p0 = pushes;
    full = 1;
    fork
      apb(1, 4'h0, 32'h1234_5678, rd, err, lat);
      begin
        wait (penable);
        @(posedge clk); #1 pwdata = 32'h0;
        repeat (2) @(posedge clk);
        #1 full = 0;
      end
    join
    check("stall_lat", lat, 4);
    check("stall_err", {31'd0, err}, 0);
    #10;
    check("stall_n", pushes - p0, 1);
    check("stall_data", last_data, 32'h1234_5678);

    apb(1, 4'h8, 32'h3, rd, err, lat);
    check("clr_err", {31'd0, err}, 0);
    p0 = pushes;
    full = 1;
    apb(1, 4'h0, 32'hCAFE_0001, rd, err, lat);
    check("to_lat", lat, 16);
    check("to_err", {31'd0, err}, 1);
    apb(0, 4'h4, 0, rd, err, lat);
    check("to_stat", rd, 32'h3);
    check("to_n", pushes - p0, 0);
    full = 0;

    apb(1, 4'h8, 32'h0, rd, err, lat);
    p0 = pushes;
    apb(1, 4'h0, 32'hAAAA_0000, rd, err, lat);
    check("dis_err", {31'd0, err}, 1);
    check("dis_lat", lat, 1);
    #10;
    check("dis_n", pushes - p0, 0);
    apb(0, 4'h8, 0, rd, err, lat);
    check("dis_ctrl", rd, 0);
    apb(1, 4'h8, 32'h3, rd, err, lat);
    apb(0, 4'h8, 0, rd, err, lat);
    check("en_ctrl", rd, 32'h1);
    apb(0, 4'h4, 0, rd, err, lat);
    check("en_stat", rd, 0);

    p0 = pushes;
    for (int i = 0; i < 255; i++) begin
      apb(1, 4'h0, i, rd, err, lat);
    end
    apb(0, 4'h4, 0, rd, err, lat);
    check("cnt_255", rd, 32'h0000_FF00);
    apb(1, 4'h0, 32'hFF, rd, err, lat);
    apb(0, 4'h4, 0, rd, err, lat);
    check("cnt_wrap", rd, 0);
    check("cnt_n", pushes - p0, 256);

    apb(0, 4'hC, 0, rd, err, lat);
    check("a3_err", {31'd0, err}, 1);
    check("a3_prdata", rd, 0);
    apb(0, 4'h0, 0, rd, err, lat);
    check("drd_err", {31'd0, err}, 1);
    check("drd_prdata", rd, 0);
    apb(1, 4'h4, 32'hFFFF_FFFF, rd, err, lat);
    check("swr_err", {31'd0, err}, 1);
    apb(0, 4'h4, 0, rd, err, lat);
    check("swr_stat", rd, 0);

    p0 = pushes;
    full = 1;
    fork
      apb(1, 4'h0, 32'hBEEF_0015, rd, err, lat);
      begin
        wait (penable);
        repeat (15) @(posedge clk);
        #1 full = 0;
      end
    join
    check("edge_lat", lat, 16);
    check("edge_err", {31'd0, err}, 0);
    #10;
    check("edge_n", pushes - p0, 1);
    apb(0, 4'h4, 0, rd, err, lat);
    check("edge_stat", rd, 32'h0000_0100);

    p0 = pushes;
    full = 1;
    @(negedge clk);
    psel = 1; pwrite = 1; paddr = 0; pwdata = 32'h7777;
    @(negedge clk);
    penable = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1; psel = 0; penable = 0;
    @(posedge clk); #1;
    check("rstw_pready", {31'd0, pready}, 0);
    check("rstw_write", {31'd0, write}, 0);
    rst = 0;
    full = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rstw_n", pushes - p0, 0);
    apb(0, 4'h8, 0, rd, err, lat);
    check("rstw_ctrl", rd, 32'h1);
    apb(0, 4'h4, 0, rd, err, lat);
    check("rstw_stat", rd, 0);

    check("strobe_ok", bad_strobe, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
